// File: rtl/phase_shift_ctrl.sv
// ADC sample-clock DCM phase-shift sequencer.
// Steps PSEN/PSINCDEC one tap at a time until the applied offset matches the target.
module phase_shift_ctrl #(
    parameter int PS_WIDTH       = 9,
    parameter int MAX_PHASE      = 255,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PS_WIDTH-1:0] phase_i,
    input  logic                phase_ld_i,
    output logic [PS_WIDTH-1:0] phase_o,
    output logic                phase_done_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                dcm_psen_o,
    output logic                dcm_psincdec_o,
    input  logic                dcm_psdone_i,
    input  logic                dcm_locked_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic signed [PS_WIDTH-1:0] MAX_P   = PS_WIDTH'(MAX_PHASE);
    localparam logic signed [PS_WIDTH-1:0] MIN_P   = PS_WIDTH'(-MAX_PHASE);
    localparam logic signed [PS_WIDTH-1:0] ONE_P   = PS_WIDTH'(1);
    localparam logic        [TW-1:0]       TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic        [TW-1:0]       ONE_T   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_STEP,
        S_WAIT_DONE,
        S_WAIT_LOCK
    } state_e;

    state_e                     state_q, state_d;
    logic signed [PS_WIDTH-1:0] phase_q, phase_d;
    logic signed [PS_WIDTH-1:0] target_q, target_d;
    logic signed [PS_WIDTH-1:0] phase_in_s, phase_clamped;
    logic                       dir_q, dir_d;
    logic                       err_q, err_d;
    logic [TW-1:0]              timer_q, timer_d;

    assign phase_in_s = $signed(phase_i);

    always_comb begin
        phase_clamped = phase_in_s;
        if (phase_in_s > MAX_P) begin
            phase_clamped = MAX_P;
        end else if (phase_in_s < MIN_P) begin
            phase_clamped = MIN_P;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        target_d     = target_q;
        dir_d        = dir_q;
        err_d        = err_q;
        timer_d      = timer_q;
        phase_done_o = 1'b0;

        if (phase_ld_i) begin
            target_d = phase_clamped;
            err_d    = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (phase_ld_i) begin
                    state_d = dcm_locked_i ? S_CMP : S_WAIT_LOCK;
                end
            end
            S_CMP: begin
                // A fresh load defers the decision one cycle to compare against it
                if (!phase_ld_i) begin
                    if (phase_q == target_q) begin
                        phase_done_o = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        dir_d   = (phase_q < target_q);
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                timer_d = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (dcm_psdone_i) begin
                    phase_d = dir_q ? phase_q + ONE_P : phase_q - ONE_P;
                    state_d = S_CMP;
                end else if (timer_q == TO_LAST) begin
                    err_d   = !phase_ld_i;
                    state_d = phase_ld_i ? S_CMP : S_IDLE;
                end else begin
                    timer_d = timer_q + ONE_T;
                end
            end
            S_WAIT_LOCK: begin
                if (dcm_locked_i) begin
                    state_d = S_CMP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The DCM zeroes its offset on relock, so any step in flight is lost
        if (!dcm_locked_i) begin
            phase_d      = '0;
            phase_done_o = 1'b0;
            if (state_q != S_IDLE) begin
                state_d = S_WAIT_LOCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    assign phase_o        = phase_q;
    assign busy_o         = (state_q != S_IDLE);
    assign err_o          = err_q;
    assign dcm_psen_o     = (state_q == S_STEP) && dcm_locked_i;
    assign dcm_psincdec_o = dir_q;

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Randomized bench for phase_shift_ctrl with a tap-counting DCM model.
// Tracks applied phase and target at transaction level and checks step counts.
module tb_phase_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] phase_in;
    logic       phase_ld;
    logic [8:0] phase_out;
    logic       phase_done;
    logic       busy;
    logic       err;
    logic       psen;
    logic       psincdec;
    logic       psdone;
    logic       locked;

    phase_shift_ctrl #(
        .PS_WIDTH      (9),
        .MAX_PHASE     (255),
        .TIMEOUT_CYCLES(1023)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .phase_i       (phase_in),
        .phase_ld_i    (phase_ld),
        .phase_o       (phase_out),
        .phase_done_o  (phase_done),
        .busy_o        (busy),
        .err_o         (err),
        .dcm_psen_o    (psen),
        .dcm_psincdec_o(psincdec),
        .dcm_psdone_i  (psdone),
        .dcm_locked_i  (locked)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int   m_phase  = 0;
    int   m_target = 0;
    int   dcm_cnt  = 0;
    int   dcm_lat  = 4;
    logic dcm_dir  = 1'b0;
    logic no_ack   = 1'b0;

    int n_psen, n_done, n_inc, n_dec;
    int cyc_n    = 0;
    int ld_cyc   = 0;
    int done_cyc = 0;
    int psen_cyc = 0;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp9(input logic [8:0] v);
        int s;
        s = $signed(v);
        if (s > 255) s = 255;
        if (s < -255) s = -255;
        return s;
    endfunction

    function automatic int sphase();
        return $signed(phase_out);
    endfunction

    task automatic clr_counts();
        n_psen = 0;
        n_done = 0;
        n_inc  = 0;
        n_dec  = 0;
    endtask

    // One clock: DCM answers, outputs are sampled and the model advances
    task automatic cyc();
        logic s_psen, s_done;
        psdone = (dcm_cnt == 1);
        #1;
        s_psen = psen;
        s_done = phase_done;
        if (!reset) begin
            check("phase", sphase(), m_phase);
            if (s_done) begin
                n_done++;
                done_cyc = cyc_n;
                check("done_tgt", sphase(), m_target);
                check("done_psen", {31'b0, s_psen}, 0);
                check("done_ld", {31'b0, phase_ld}, 0);
            end
            if (s_psen) begin
                n_psen++;
                psen_cyc = cyc_n;
                check("psen_lock", {31'b0, locked}, 1);
                if (psincdec) n_inc++;
                else n_dec++;
            end
        end
        if (phase_ld) ld_cyc = cyc_n;
        if (reset) begin
            m_phase  = 0;
            m_target = 0;
            dcm_cnt  = 0;
        end else begin
            if (phase_ld) m_target = clamp9(phase_in);
            if (!locked) begin
                m_phase = 0;
                dcm_cnt = 0;
            end else begin
                if (dcm_cnt == 1) m_phase += dcm_dir ? 1 : -1;
                if (dcm_cnt > 0) dcm_cnt--;
                if (s_psen && !no_ack) begin
                    dcm_cnt = dcm_lat;
                    dcm_dir = psincdec;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        phase_ld = 1'b0;
    endtask

    task automatic load(input logic [8:0] v);
        phase_in = v;
        phase_ld = 1'b1;
        cyc();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            cyc();
            n++;
        end
        check("idle", {31'b0, busy}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic run_load(input logic [8:0] v, input int lat);
        int p0, t;
        p0      = m_phase;
        t       = clamp9(v);
        dcm_lat = lat;
        clr_counts();
        load(v);
        wait_idle(20000);
        check("inc", n_inc, (t > p0) ? t - p0 : 0);
        check("dec", n_dec, (t < p0) ? p0 - t : 0);
        check("done_cnt", n_done, 1);
        check("final", sphase(), t);
        check("err_clr", {31'b0, err}, 0);
    endtask

    initial begin
        int n, t0;
        reset    = 1'b1;
        phase_in = '0;
        phase_ld = 1'b0;
        psdone   = 1'b0;
        locked   = 1'b1;

        do_reset();
        check("rst_phase", {23'b0, phase_out}, 0);
        check("rst_done", {31'b0, phase_done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_psen", {31'b0, psen}, 0);
        check("rst_incdec", {31'b0, psincdec}, 0);

        run_load(9'd3, 4);
        run_load(9'h1FE, 4);
        check("raw_m2", {23'b0, phase_out}, 'h1FE);

        run_load(9'h100, 2);
        check("raw_clamp", {23'b0, phase_out}, 'h101);

        run_load(9'h101, 2);
        check("psen_none", n_psen, 0);
        check("done_lat", done_cyc - ld_cyc, 1);

        // Retarget while the 4th step is outstanding
        do_reset();
        dcm_lat = 4;
        clr_counts();
        load(9'd10);
        n = 0;
        while (n_psen < 4 && n < 200) begin
            cyc();
            n++;
        end
        check("psen4", n_psen, 4);
        load(9'd2);
        wait_idle(500);
        check("rt_inc", n_inc, 4);
        check("rt_dec", n_dec, 2);
        check("rt_done", n_done, 1);
        check("rt_final", sphase(), 2);

        // DCM never answers
        no_ack = 1'b1;
        clr_counts();
        load(9'd5);
        wait_idle(1200);
        t0 = cyc_n - psen_cyc;
        check("to_err", {31'b0, err}, 1);
        check("to_done", n_done, 0);
        check("to_psen", n_psen, 1);
        check("to_len", {31'b0, (t0 >= 1023 && t0 <= 1026)}, 1);
        no_ack = 1'b0;
        clr_counts();
        load(9'd2);
        check("to_errclr", {31'b0, err}, 0);
        wait_idle(50);
        check("to_redone", n_done, 1);

        // Lock loss mid-sequence
        do_reset();
        dcm_lat = 3;
        clr_counts();
        load(9'd8);
        n = 0;
        while (sphase() != 5 && n < 300) begin
            cyc();
            n++;
        end
        check("reach5", sphase(), 5);
        locked = 1'b0;
        repeat (6) begin
            cyc();
            check("lk_busy", {31'b0, busy}, 1);
        end
        check("lk_zero", sphase(), 0);
        locked = 1'b1;
        wait_idle(500);
        check("lk_inc", n_inc, 13);
        check("lk_dec", n_dec, 0);
        check("lk_done", n_done, 1);
        check("lk_final", sphase(), 8);

        // Lock loss while idle, then a load before relock
        locked = 1'b0;
        repeat (2) cyc();
        check("il_busy", {31'b0, busy}, 0);
        clr_counts();
        load(9'd3);
        repeat (3) begin
            cyc();
            check("wl_busy", {31'b0, busy}, 1);
        end
        locked = 1'b1;
        wait_idle(200);
        check("wl_inc", n_inc, 3);
        check("wl_done", n_done, 1);
        check("wl_final", sphase(), 3);

        for (int i = 0; i < 8; i++) begin
            run_load(9'($urandom_range(0, 511)), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
